// File: rtl/gl_lockstep_checker_if.sv
// Stimulus bundle for the lockstep checker: the golden-model stream and the
// gate-level stream, plus the per-compare bit mask.
interface gl_lockstep_checker_if #(
    parameter int WIDTH = 32
) ();
    logic             rtl_valid;
    logic [WIDTH-1:0] rtl_data;
    logic             gl_valid;
    logic [WIDTH-1:0] gl_data;
    logic [WIDTH-1:0] cmp_mask;

    // Driver side (testbench / harness producing both streams)
    modport master (
        output rtl_valid,
        output rtl_data,
        output gl_valid,
        output gl_data,
        output cmp_mask
    );

    // Checker side
    modport slave (
        input rtl_valid,
        input rtl_data,
        input gl_valid,
        input gl_data,
        input cmp_mask
    );
endinterface

// File: rtl/gl_lockstep_checker.sv
// Lockstep comparator between a golden RTL model and a gate-level netlist.
// Expected words are queued in a small FIFO until the matching observed word
// arrives; each compare is masked, counted, and the first failure is captured.
module gl_lockstep_checker #(
    parameter int WIDTH            = 32,
    parameter int DEPTH            = 8,   // power of two, 2..64
    parameter int HALT_ON_MISMATCH = 1
) (
    input  logic                       CK,
    input  logic                       C,
    gl_lockstep_checker_if.slave       bus,
    output logic                       mismatch,
    output logic [15:0]                mismatch_count,
    output logic [31:0]                compare_count,
    output logic [31:0]                first_idx,
    output logic [WIDTH-1:0]           first_exp,
    output logic [WIDTH-1:0]           first_act,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [AW:0]      level_next;
    logic             mismatch_reg;
    logic [15:0]      mismatch_count_reg;
    logic [31:0]      compare_count_reg;
    logic [31:0]      first_idx_reg;
    logic [WIDTH-1:0] first_exp_reg;
    logic [WIDTH-1:0] first_act_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             halted_reg;

    logic             fifo_empty;
    logic             fifo_full;
    logic             active;
    logic             do_push;
    logic             do_pop;
    logic             do_cmp;
    logic             set_overflow;
    logic             set_underflow;
    logic             cmp_fail;
    logic [WIDTH-1:0] head_word;
    logic [WIDTH-1:0] exp_word;

    // Decode this cycle's FIFO/compare actions from the two valid strobes
    always_comb begin
        fifo_empty = (wr_ptr_reg == rd_ptr_reg);
        fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
        // The IDLE->RUN cycle is processed exactly like a RUN cycle
        active     = (state_reg == RUN) ||
                     ((state_reg == IDLE) && (bus.rtl_valid || bus.gl_valid));
        head_word  = mem[rd_ptr_reg[AW-1:0]];

        // Pop whenever an observed word meets a queued one; with an empty
        // FIFO a simultaneous expected word is compared directly (bypass)
        do_pop        = active && bus.gl_valid && !fifo_empty;
        do_cmp        = active && bus.gl_valid && (bus.rtl_valid || !fifo_empty);
        // Push unless the word is consumed by bypass, or the FIFO is full
        // with no simultaneous pop freeing a slot
        do_push       = active && bus.rtl_valid &&
                        !(bus.gl_valid && fifo_empty) &&
                        (!fifo_full || bus.gl_valid);
        set_overflow  = active && bus.rtl_valid && !bus.gl_valid && fifo_full;
        set_underflow = active && bus.gl_valid && !bus.rtl_valid && fifo_empty;

        exp_word = fifo_empty ? bus.rtl_data : head_word;
        cmp_fail = do_cmp && (((exp_word ^ bus.gl_data) & bus.cmp_mask) != '0);

        level_next = level_reg;
        case ({do_push, do_pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // FIFO storage: no reset, pointers alone define the valid contents
    always_ff @(posedge CK) begin
        if (!C && do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= bus.rtl_data;
        end
    end

    // Control FSM, pointers, counters, sticky flags and first-failure capture
    always_ff @(posedge CK) begin
        if (C) begin
            state_reg          <= IDLE;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            level_reg          <= '0;
            mismatch_reg       <= 1'b0;
            mismatch_count_reg <= '0;
            compare_count_reg  <= '0;
            first_idx_reg      <= '0;
            first_exp_reg      <= '0;
            first_act_reg      <= '0;
            overflow_reg       <= 1'b0;
            underflow_reg      <= 1'b0;
            halted_reg         <= 1'b0;
        end else begin
            mismatch_reg <= 1'b0;

            case (state_reg)
                IDLE:    if (bus.rtl_valid || bus.gl_valid) state_reg <= RUN;
                RUN:     state_reg <= RUN;
                HALT:    state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase

            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;

            if (set_overflow)  overflow_reg  <= 1'b1;
            if (set_underflow) underflow_reg <= 1'b1;

            if (do_cmp) compare_count_reg <= compare_count_reg + 32'd1;

            if (cmp_fail) begin
                mismatch_reg <= 1'b1;
                if (mismatch_count_reg != 16'hFFFF) begin
                    mismatch_count_reg <= mismatch_count_reg + 16'd1;
                end
                // Count never returns to zero without reset, so zero marks
                // "no failure captured yet"
                if (mismatch_count_reg == 16'd0) begin
                    first_idx_reg <= compare_count_reg;
                    first_exp_reg <= exp_word;
                    first_act_reg <= bus.gl_data;
                end
                if (HALT_ON_MISMATCH != 0) begin
                    state_reg  <= HALT;
                    halted_reg <= 1'b1;
                end
            end
        end
    end

    assign mismatch       = mismatch_reg;
    assign mismatch_count = mismatch_count_reg;
    assign compare_count  = compare_count_reg;
    assign first_idx      = first_idx_reg;
    assign first_exp      = first_exp_reg;
    assign first_act      = first_act_reg;
    assign overflow       = overflow_reg;
    assign underflow      = underflow_reg;
    assign halted         = halted_reg;
    assign fifo_level     = level_reg;

endmodule
